// File: rtl/score_display_pkg.sv
// Shared types, constants and helpers for the score display path.
package score_display_pkg;

    // Conversion engine state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // The 10-nibble accumulator covers the full 32-bit input range
    localparam int BCD_DIGITS = 10;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    // Segment patterns {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [3:0] SAT_DIGIT  = 4'd9;
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Map a BCD digit to its segment pattern; non-decimal codes go dark
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] code;
        if (digit <= 4'd9) begin
            code = SEG_TABLE[digit];
        end else begin
            code = SEG_BLANK;
        end
        return code;
    endfunction

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end else begin
                res[i*4 +: 4] = bcd[i*4 +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per clock.
// o_done is high for the single COMMIT cycle, when o_bcd and o_value
// hold the finished result and the value it was computed from.
module bin2bcd_seq
    import score_display_pkg::*;
#(
    parameter int SCORE_W = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [SCORE_W-1:0] i_value,
    input  logic               i_go,
    output logic [BCD_W-1:0]   o_bcd,
    output logic               o_done,
    output logic               o_busy,
    output logic [SCORE_W-1:0] o_value
);

    localparam int CNT_W = $clog2(SCORE_W + 1);

    state_t             r_state;
    logic [SCORE_W-1:0] r_shift;
    logic [SCORE_W-1:0] r_value;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [BCD_W-1:0]   w_adj;

    assign w_adj   = dabble_adjust(r_bcd);
    assign o_bcd   = r_bcd;
    assign o_done  = (r_state == ST_COMMIT);
    assign o_busy  = r_busy;
    assign o_value = r_value;

    // Conversion FSM: capture on go, shift SCORE_W times, then one commit cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_value <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_go) begin
                        r_value <= i_value;
                        r_shift <= i_value;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_bcd   <= {w_adj[BCD_W-2:0], r_shift[SCORE_W-1]};
                    r_shift <= {r_shift[SCORE_W-2:0], 1'b0};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(SCORE_W - 1)) begin
                        r_state <= ST_COMMIT;
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_COMMIT: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/score_display.sv
// Score display: detects score changes, converts to BCD, saturates at
// 9999 and scans four common-anode digits with leading-zero blanking.
module score_display
    import score_display_pkg::*;
#(
    parameter int SCORE_W     = 32,
    parameter int REFRESH_DIV = 100000
) (
    input  logic               clock_div,
    input  logic               start,
    input  logic [SCORE_W-1:0] score,
    output logic [3:0]         an,
    output logic [6:0]         seg,
    output logic               dp,
    output logic               busy,
    output logic               overflow
);

    localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [SCORE_W-1:0] r_last_score;
    logic [3:0][3:0]    r_digits;
    logic               r_overflow;
    logic [REF_W-1:0]   r_refresh_cnt;
    logic [1:0]         r_scan_idx;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp;

    logic               w_go;
    logic [BCD_W-1:0]   w_bcd;
    logic               w_done;
    logic               w_busy;
    logic [SCORE_W-1:0] w_value;
    logic [3:0]         w_blank;
    logic [3:0]         w_an_next;
    logic [6:0]         w_seg_next;
    logic               w_dp_next;

    // Only sampled while the engine is idle, so a mid-conversion change
    // is picked up right after the commit.
    assign w_go = (score != r_last_score);

    bin2bcd_seq #(
        .SCORE_W (SCORE_W)
    ) u_bin2bcd (
        .i_clk   (clock_div),
        .i_rst_n (start),
        .i_value (score),
        .i_go    (w_go),
        .o_bcd   (w_bcd),
        .o_done  (w_done),
        .o_busy  (w_busy),
        .o_value (w_value)
    );

    assign busy     = w_busy;
    assign overflow = r_overflow;
    assign an       = r_an;
    assign seg      = r_seg;
    assign dp       = r_dp;

    // Digit registers update only on commit, so the scan never shows a torn value
    always_ff @(posedge clock_div or negedge start) begin
        if (!start) begin
            r_last_score <= '0;
            r_digits     <= '0;
            r_overflow   <= 1'b0;
        end else if (w_done) begin
            r_last_score <= w_value;
            if (|w_bcd[BCD_W-1:16]) begin
                r_digits   <= {SAT_DIGIT, SAT_DIGIT, SAT_DIGIT, SAT_DIGIT};
                r_overflow <= 1'b1;
            end else begin
                r_digits   <= w_bcd[15:0];
                r_overflow <= 1'b0;
            end
        end else begin
            r_last_score <= r_last_score;
            r_digits     <= r_digits;
            r_overflow   <= r_overflow;
        end
    end

    // Free-running refresh divider; each wrap advances the scanned digit
    always_ff @(posedge clock_div or negedge start) begin
        if (!start) begin
            r_refresh_cnt <= '0;
            r_scan_idx    <= 2'd0;
        end else if (r_refresh_cnt == REF_W'(REFRESH_DIV - 1)) begin
            r_refresh_cnt <= '0;
            r_scan_idx    <= r_scan_idx + 2'd1;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
            r_scan_idx    <= r_scan_idx;
        end
    end

    // Leading-zero blanking and next pin values for the scanned digit
    always_comb begin
        w_blank    = 4'b0000;
        w_blank[3] = (r_digits[3] == 4'd0);
        w_blank[2] = w_blank[3] && (r_digits[2] == 4'd0);
        w_blank[1] = w_blank[2] && (r_digits[1] == 4'd0);
        w_blank[0] = 1'b0;
        w_an_next  = ~(4'b0001 << r_scan_idx);
        if (w_blank[r_scan_idx]) begin
            w_seg_next = SEG_BLANK;
        end else begin
            w_seg_next = seg_encode(r_digits[r_scan_idx]);
        end
        if (r_overflow && (r_scan_idx == 2'd0)) begin
            w_dp_next = 1'b0;
        end else begin
            w_dp_next = 1'b1;
        end
    end

    // Registered display pins
    always_ff @(posedge clock_div or negedge start) begin
        if (!start) begin
            r_an  <= 4'b1110;
            r_seg <= SEG_TABLE[0];
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
            r_dp  <= w_dp_next;
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with a short refresh period.
module tb_score_display;

    logic        clock_div = 1'b0;
    logic        start     = 1'b0;
    logic [31:0] score     = 32'd0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int n_busy;

    always #5 clock_div = ~clock_div;

    score_display #(
        .SCORE_W     (32),
        .REFRESH_DIV (4)
    ) dut (
        .clock_div (clock_div),
        .start     (start),
        .score     (score),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .busy      (busy),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_div);
        @(negedge clock_div);
    endtask

    // Count busy-high samples until busy falls (bounded)
    task automatic wait_conv(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (busy) begin
                n++;
            end else if (n > 0) begin
                break;
            end
        end
    endtask

    // Watch 16 scan cycles and check every lit digit against expectations
    task automatic show(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                        input logic [6:0] e1, input logic [6:0] e0, input logic ov);
        logic [6:0] exp_seg [4];
        logic [3:0] seen;
        int         p;
        exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
        seen = 4'h0;
        tick();
        chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, ov});
        for (int c = 0; c < 16; c++) begin
            tick();
            p = 0;
            for (int k = 0; k < 4; k++) begin
                if (!an[k]) p = k;
            end
            chk({tag, "_an_onecold"}, $countones(~an), 32'd1);
            chk({tag, "_seg"}, {25'd0, seg}, {25'd0, exp_seg[p]});
            chk({tag, "_dp"}, {31'd0, dp}, {31'd0, (ov && p == 0) ? 1'b0 : 1'b1});
            seen[p] = 1'b1;
        end
        chk({tag, "_positions"}, {28'd0, seen}, 32'hF);
    endtask

    initial begin
        logic [3:0] ea;

        // Reset state
        start = 1'b0;
        score = 32'd0;
        repeat (3) tick();
        chk("rst_an", {28'd0, an}, 32'hE);
        chk("rst_seg", {25'd0, seg}, 32'h40);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);

        // Release with score 0: no conversion, exact scan order
        start = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            ea = ~(4'b0001 << (((i - 1) / 4) % 4));
            chk("scan_an", {28'd0, an}, {28'd0, ea});
            chk("scan_seg", {25'd0, seg}, (ea == 4'b1110) ? 32'h40 : 32'h7F);
            chk("idle_busy", {31'd0, busy}, 32'd0);
        end

        // 1234
        score = 32'd1234;
        wait_conv(n_busy);
        chk("busy_1234", n_busy, 32'd33);
        show("d1234", 7'h79, 7'h24, 7'h30, 7'h19, 1'b0);

        // 50: hundreds and thousands blanked
        score = 32'd50;
        wait_conv(n_busy);
        chk("busy_50", n_busy, 32'd33);
        show("d50", 7'h7F, 7'h7F, 7'h12, 7'h40, 1'b0);

        // 123456 saturates
        score = 32'd123456;
        wait_conv(n_busy);
        chk("busy_sat", n_busy, 32'd33);
        show("dsat", 7'h10, 7'h10, 7'h10, 7'h10, 1'b1);

        // 10, then 20 mid-conversion
        score = 32'd10;
        repeat (5) tick();
        score = 32'd20;
        wait_conv(n_busy);
        chk("busy_10_rest", n_busy, 32'd28);
        show("d10", 7'h7F, 7'h7F, 7'h79, 7'h40, 1'b0);
        wait_conv(n_busy);
        chk("busy_20_rest", n_busy, 32'd16);
        show("d20", 7'h7F, 7'h7F, 7'h24, 7'h40, 1'b0);

        // Reset during SHIFT of 777
        score = 32'd777;
        repeat (5) tick();
        chk("shift_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        #1;
        chk("mid_rst_an", {28'd0, an}, 32'hE);
        chk("mid_rst_seg", {25'd0, seg}, 32'h40);
        chk("mid_rst_dp", {31'd0, dp}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clock_div);
        start = 1'b1;
        wait_conv(n_busy);
        chk("busy_777", n_busy, 32'd33);
        show("d777", 7'h7F, 7'h78, 7'h78, 7'h78, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
